// File: rtl/fc_stream_mac.sv
// Streaming fully-connected layer: buffers activations, then computes OUT_COUNT requantised neurons.
// Optional build macro FC_RELU_EN clamps negative shifted accumulators to zero before saturation.
module fc_stream_mac #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned IN_COUNT   = 1024,
  parameter int unsigned OUT_COUNT  = 1000,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned SHIFT      = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [LANES*DATA_WIDTH-1:0] act_data,
  input  logic                        act_valid,
  output logic                        act_ready,
  input  logic [LANES*DATA_WIDTH-1:0] wgt_data,
  input  logic                        wgt_valid,
  output logic                        wgt_ready,
  input  logic [ACC_WIDTH-1:0]        bias_data,
  input  logic                        bias_valid,
  output logic                        bias_ready,
  output logic [OUT_WIDTH-1:0]        result,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned BEATS = IN_COUNT / LANES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned NW    = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
  localparam int unsigned VW    = LANES * DATA_WIDTH;
  localparam logic [BW-1:0] LAST_BEAT   = BW'(BEATS - 1);
  localparam logic [NW-1:0] LAST_NEURON = NW'(OUT_COUNT - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  if ((IN_COUNT % LANES) != 0) begin : g_param_check
    $error("fc_stream_mac: IN_COUNT must be a multiple of LANES");
  end

  typedef enum logic [2:0] {StIdle, StLoadAct, StLoadBias, StMac, StEmit, StDone} state_e;

  state_e                        state_q, state_d;
  logic [BW-1:0]                 beat_q, beat_d;
  logic [NW-1:0]                 neuron_q, neuron_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [VW-1:0]                 act_buf [BEATS];
  logic [VW-1:0]                 act_word;
  logic signed [ACC_WIDTH-1:0]   dot;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]   shifted;
  logic [OUT_WIDTH-1:0]          sat;
  logic                          act_fire, wgt_fire, bias_fire, res_fire;

  assign act_ready    = (state_q == StLoadAct);
  assign bias_ready   = (state_q == StLoadBias);
  assign wgt_ready    = (state_q == StMac);
  assign result_valid = (state_q == StEmit);
  assign done         = (state_q == StDone);
  assign busy         = (state_q != StIdle);

  assign act_fire  = act_valid && act_ready;
  assign wgt_fire  = wgt_valid && wgt_ready;
  assign bias_fire = bias_valid && bias_ready;
  assign res_fire  = result_valid && result_ready;

  // Buffer holds its contents through reset; it is always reloaded before use.
  always_ff @(posedge clock) begin
    if (act_fire) act_buf[beat_q] <= act_data;
  end

  assign act_word = act_buf[beat_q];

  always_comb begin
    dot  = '0;
    prod = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      prod = $signed(act_word[l*DATA_WIDTH +: DATA_WIDTH]) *
             $signed(wgt_data[l*DATA_WIDTH +: DATA_WIDTH]);
      dot  = dot + ACC_WIDTH'(prod);
    end
  end

  always_comb begin
    shifted = acc_q >>> SHIFT;
`ifdef FC_RELU_EN
    if (shifted < 0) shifted = '0;
`else
`endif
    if (shifted > OUT_MAX)      sat = OUT_MAX[OUT_WIDTH-1:0];
    else if (shifted < OUT_MIN) sat = OUT_MIN[OUT_WIDTH-1:0];
    else                        sat = shifted[OUT_WIDTH-1:0];
  end

  // Gate with state so nothing partial is visible outside EMIT.
  assign result = (state_q == StEmit) ? sat : '0;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    neuron_d = neuron_q;
    acc_d    = acc_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StLoadAct;
          beat_d   = '0;
          neuron_d = '0;
        end
      end
      StLoadAct: begin
        if (act_fire) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = StLoadBias;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StLoadBias: begin
        if (bias_fire) begin
          acc_d   = bias_data;
          state_d = StMac;
        end
      end
      StMac: begin
        if (wgt_fire) begin
          acc_d = acc_q + dot;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = StEmit;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StEmit: begin
        if (res_fire) begin
          if (neuron_q == LAST_NEURON) begin
            state_d = StDone;
          end else begin
            neuron_d = neuron_q + 1'b1;
            state_d  = StLoadBias;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      neuron_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      neuron_q <= neuron_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: tb/tb_fc_stream_mac.sv
// Directed self-checking bench for fc_stream_mac (4 lanes, 16 inputs, 2 neurons, no shift).
module tb_fc_stream_mac;

  localparam int unsigned DW = 8;
  localparam int unsigned LN = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned OW = 16;

`ifdef FC_RELU_EN
  localparam int EXP_NEG0 = 0;
  localparam int EXP_NEG1 = 0;
  localparam int EXP_SATN = 0;
`else
  localparam int EXP_NEG0 = -30;
  localparam int EXP_NEG1 = -20;
  localparam int EXP_SATN = -32768;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [LN*DW-1:0]  act_data;
  logic              act_valid;
  logic              act_ready;
  logic [LN*DW-1:0]  wgt_data;
  logic              wgt_valid;
  logic              wgt_ready;
  logic [AW-1:0]     bias_data;
  logic              bias_valid;
  logic              bias_ready;
  logic [OW-1:0]     result;
  logic              result_valid;
  logic              result_ready;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fc_stream_mac #(
    .DATA_WIDTH(DW), .LANES(LN), .IN_COUNT(16), .OUT_COUNT(2),
    .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(0)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .act_data(act_data), .act_valid(act_valid), .act_ready(act_ready),
    .wgt_data(wgt_data), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
    .bias_data(bias_data), .bias_valid(bias_valid), .bias_ready(bias_ready),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rexp(input int v);
    logic [OW-1:0] r;
    r = OW'(v);
    return {16'h0, r};
  endfunction

  task automatic check_zero(input string tag);
    check(tag, {19'h0, busy, done, result_valid, act_ready, wgt_ready, bias_ready, 7'h0}, 32'h0);
    check({tag, "_res"}, {16'h0, result}, 32'h0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic xfer_act(input logic [31:0] d);
    int n = 0;
    act_data  = d;
    act_valid = 1'b1;
    while (!act_ready && n < 50) begin @(negedge clock); n++; end
    check("act_rdy", 32'(act_ready), 32'h1);
    if (act_ready) begin @(posedge clock); @(negedge clock); end
    act_valid = 1'b0;
  endtask

  task automatic xfer_bias(input int b);
    int n = 0;
    bias_data  = 32'(b);
    bias_valid = 1'b1;
    while (!bias_ready && n < 50) begin @(negedge clock); n++; end
    check("bias_rdy", 32'(bias_ready), 32'h1);
    if (bias_ready) begin @(posedge clock); @(negedge clock); end
    bias_valid = 1'b0;
  endtask

  task automatic xfer_wgt(input logic [31:0] d);
    int n = 0;
    wgt_data  = d;
    wgt_valid = 1'b1;
    while (!wgt_ready && n < 50) begin @(negedge clock); n++; end
    check("wgt_rdy", 32'(wgt_ready), 32'h1);
    if (wgt_ready) begin @(posedge clock); @(negedge clock); end
    wgt_valid = 1'b0;
  endtask

  task automatic load_acts(input logic [31:0] d);
    for (int i = 0; i < 4; i++) xfer_act(d);
  endtask

  task automatic send_wgts(input logic [31:0] d, input bit gap);
    for (int i = 0; i < 4; i++) begin
      xfer_wgt(d);
      if (gap && i < 3) @(negedge clock);
    end
    check("latency", 32'(result_valid), 32'h1);
  endtask

  task automatic get_result(input string tag, input int exp);
    int n = 0;
    while (!result_valid && n < 100) begin @(negedge clock); n++; end
    check({tag, "_valid"}, 32'(result_valid), 32'h1);
    check(tag, {16'h0, result}, rexp(exp));
    result_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    result_ready = 1'b0;
  endtask

  task automatic check_done();
    check("done_pulse", {30'h0, done, busy}, 32'h3);
    @(negedge clock);
    check("done_clear", {30'h0, done, busy}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    act_data = '0; act_valid = 1'b0;
    wgt_data = '0; wgt_valid = 1'b0;
    bias_data = '0; bias_valid = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Basic: each act beat sums to 10, four beats -> 40 with unit weights.
    pulse_start();
    check("start_load", {30'h0, act_ready, busy}, 32'h3);
    load_acts(32'h04030201);
    xfer_bias(10);
    send_wgts(32'h01010101, 1'b0);
    get_result("basic0", 50);
    check("next_bias", {31'h0, bias_ready}, 32'h1);
    xfer_bias(20);
    send_wgts(32'h01010101, 1'b0);
    get_result("basic1", 60);
    check_done();

    // Negative weights with backpressure on the first neuron.
    pulse_start();
    load_acts(32'h04030201);
    xfer_bias(10);
    send_wgts(32'hFFFFFFFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(result_valid), 32'h1);
      check("bp_result", {16'h0, result}, rexp(EXP_NEG0));
      check("bp_readys", {30'h0, wgt_ready, bias_ready}, 32'h0);
      @(negedge clock);
    end
    get_result("neg0", EXP_NEG0);
    xfer_bias(20);
    send_wgts(32'hFFFFFFFF, 1'b0);
    get_result("neg1", EXP_NEG1);
    check_done();

    // Saturation: +/-16*127*127ish products far exceed 16-bit range.
    pulse_start();
    load_acts(32'h7F7F7F7F);
    xfer_bias(0);
    send_wgts(32'h7F7F7F7F, 1'b0);
    get_result("sat_pos", 32767);
    xfer_bias(0);
    send_wgts(32'h80808080, 1'b0);
    get_result("sat_neg", EXP_SATN);
    check_done();

    // Gapped weights and a stray start while busy.
    pulse_start();
    load_acts(32'h04030201);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_ignored", {30'h0, busy, bias_ready}, 32'h3);
    xfer_bias(10);
    send_wgts(32'h01010101, 1'b1);
    get_result("gap0", 50);
    xfer_bias(20);
    send_wgts(32'h01010101, 1'b1);
    get_result("gap1", 60);
    check_done();

    // Reset in the middle of MAC, then a clean layer.
    pulse_start();
    load_acts(32'h04030201);
    xfer_bias(10);
    xfer_wgt(32'h01010101);
    xfer_wgt(32'h01010101);
    check("mid_mac", 32'(wgt_ready), 32'h1);
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_zero("post_reset");
    pulse_start();
    load_acts(32'h04030201);
    xfer_bias(10);
    send_wgts(32'h01010101, 1'b0);
    get_result("fresh0", 50);
    xfer_bias(20);
    send_wgts(32'h01010101, 1'b0);
    get_result("fresh1", 60);
    check_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_stream_mac.md
Name: fc_stream_mac

Overview:
- Parametrised fully-connected layer engine for the MobileNet classifier head. Generalises the single-stream fc block.
- Activations are loaded once into an internal buffer. The block then computes OUT_COUNT neurons, each from one bias beat and IN_COUNT/LANES packed weight beats.
- Each neuron result is requantised (arithmetic shift plus saturation) and emitted over a valid/ready handshake.
- Sits between the global-average-pool output FIFO and the softmax/argmax stage.

Parameters:
- DATA_WIDTH, 8, signed width of each activation/weight lane
- LANES, 4, lanes per beat; IN_COUNT must be a multiple of LANES
- IN_COUNT, 1024, inputs per neuron
- OUT_COUNT, 1000, number of output neurons
- ACC_WIDTH, 32, signed accumulator and bias width
- OUT_WIDTH, 16, signed result width
- SHIFT, 8, arithmetic right shift applied before saturation

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin layer; sampled in IDLE only
- act_data  in  LANES*DATA_WIDTH  packed activations, lane 0 in LSBs
- act_valid  in  1  activation beat valid
- act_ready  out  1  high in LOAD_ACT
- wgt_data  in  LANES*DATA_WIDTH  packed weights, lane 0 in LSBs
- wgt_valid  in  1  weight beat valid
- wgt_ready  out  1  high in MAC
- bias_data  in  ACC_WIDTH  signed bias
- bias_valid  in  1  bias beat valid
- bias_ready  out  1  high in LOAD_BIAS
- result  out  OUT_WIDTH  signed neuron output
- result_valid  out  1  result held until accepted
- result_ready  in  1  downstream accept
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the layer completes

Behaviour:
- Reset (async, active-high): state=IDLE; every output 0; beat counter, neuron counter and accumulator cleared. The activation buffer is not cleared.
- A beat transfers on the rising edge where valid&&ready.
- IDLE: start=1 -> LOAD_ACT. start is ignored in every other state.
- LOAD_ACT: store IN_COUNT/LANES beats into buffer entries 0..N-1 in order. After the last beat -> LOAD_BIAS.
- LOAD_BIAS: on transfer, acc <= sign-extended bias_data -> MAC.
- MAC: on each transfer of weight beat k, acc <= acc + sum over lanes of (signed act_buf[k].lane * signed wgt.lane).
  - Products are 2*DATA_WIDTH wide and are sign-extended to ACC_WIDTH before summing.
  - acc wraps modulo 2^ACC_WIDTH with no overflow detection.
  - One beat per cycle is sustained.
  - After beat N-1 -> EMIT; result_valid is high in the following cycle (latency 1).
- EMIT:
  - result = saturate_OUT_WIDTH(acc >>> SHIFT), i.e. clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - result and result_valid are held stable while result_ready=0. wgt_ready and bias_ready are 0 during EMIT.
  - On transfer: if neuron==OUT_COUNT-1 -> DONE; else neuron++ and -> LOAD_BIAS.
- DONE: done=1 for exactly one cycle -> IDLE. The activation buffer stays valid but is reloaded on the next start.
- Beat counter wraps to 0 at the end of each neuron. The neuron counter clears on entry to LOAD_ACT.
- Valid on a stream whose ready is low is not consumed; the source must hold its data.
- Reset asserted mid-operation aborts immediately. No done pulse, no partial result; the next start begins a clean layer.
- Simultaneous result transfer and reset: reset wins.
- Parameter legality (IN_COUNT % LANES == 0) is checked at elaboration with $error.

Optional Feature:
- Macro FC_RELU_EN.
- Defined: after the shift and before saturation, negative values are forced to 0, so result is always >= 0.
- Undefined: signed results pass through unchanged; RTL is identical otherwise.

Test Plan:
Bench parameters: LANES=4, DATA_WIDTH=8, IN_COUNT=16, OUT_COUNT=2, SHIFT=0, OUT_WIDTH=16.
- Basic: act beats {4,3,2,1} x4; weights all +1; biases 10 and 20 -> results 50, then 60; done pulses 1 cycle after the second transfer.
- Negative: same acts, weights all -1, bias 10 -> result -30; with FC_RELU_EN -> 0.
- Saturation: acts all 127, weights all 127, bias 0 -> acc 258064 -> result 32767. Weights all -128 -> acc -260096 -> result -32768 (or 0 with FC_RELU_EN).
- Backpressure: hold result_ready=0 for 5 cycles in EMIT -> result and result_valid stable; wgt_ready=0 and bias_ready=0; correct values emitted after release.
- Gapped streams: toggle wgt_valid every other cycle -> same results as the Basic case; start pulsed while busy -> ignored, neuron count unaffected.
- Reset mid-MAC (after 2 weight beats) -> all outputs 0 and busy=0 at once. A fresh layer then produces the Basic results exactly.
